fwd_scoreboard_unit: RTL

Parametrised successor to the combinational forwarding unit. It tracks in-flight register writes through the EX, MEM, WB and any deeper stages in an internal destination-tag pipeline. Per EX-stage source operand it produces forward selects, youngest writer first. It also raises the load-use stall and bubble. It sits beside the ID/EX register and drives the EX operand muxes and the ID/IF hold logic.

---
 rtl/fwd_scoreboard_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fwd_scoreboard_unit.sv
// rtl/fwd_scoreboard_unit.sv - destination-tag scoreboard: operand forward selects, load-use stall/bubble
// Optional statistics counters are built when FWD_STATS_EN is defined.
module fwd_scoreboard_unit #(
  parameter int REG_AW    = 2,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int SW        = $clog2(FWD_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef FWD_STATS_EN
  input  logic                        stat_clr,
  output logic [15:0]                 stat_stall_cnt,
  output logic [15:0]                 stat_fwd_cnt,
`endif
  input  logic                        flush,
  input  logic                        id_valid,
  input  logic                        id_we,
  input  logic                        id_is_load,
  input  logic [REG_AW-1:0]           id_rd,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src,
  input  logic [NUM_SRC-1:0]          id_src_used,
  output logic [NUM_SRC*SW-1:0]       fwd_sel,
  output logic                        stall,
  output logic                        bubble,
  output logic                        fwd_err
);

  // Slot 0 is EX, slot k is k stages past EX.
  logic [FWD_DEPTH:0]             vld_q, vld_d;
  logic [FWD_DEPTH:0]             we_q, we_d;
  logic [FWD_DEPTH:0]             ld_q, ld_d;
  logic [FWD_DEPTH:0][REG_AW-1:0] rd_q, rd_d;
  logic [NUM_SRC*REG_AW-1:0]      ex_src_q, ex_src_d;
  logic [NUM_SRC-1:0]             ex_used_q, ex_used_d;
  logic                           ex_load;

  // Forward selects for the EX sources: scan oldest to youngest so the youngest match wins.
  always_comb begin
    logic [SW-1:0] sel;
    logic          sel_early_ld;
    fwd_sel = '0;
    fwd_err = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel          = '0;
      sel_early_ld = 1'b0;
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (vld_q[k] && we_q[k] && ex_used_q[i] &&
            (rd_q[k] == ex_src_q[i*REG_AW +: REG_AW])) begin
          sel          = SW'(k);
          sel_early_ld = ld_q[k] && (k < 1 + LOAD_LAT);
        end
      end
      fwd_sel[i*SW +: SW] = sel;
      fwd_err             = fwd_err | sel_early_ld;
    end
  end

  // Load-use stall for ID sources: youngest matching writer is a load whose data is not ready
  // by the time the consumer would reach EX; a younger non-load writer masks an older load.
  always_comb begin
    logic hit_early_ld;
    stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_early_ld = 1'b0;
      for (int j = FWD_DEPTH; j >= 0; j--) begin
        if (vld_q[j] && we_q[j] && (rd_q[j] == id_src[i*REG_AW +: REG_AW])) begin
          hit_early_ld = ld_q[j] && (j < LOAD_LAT);
        end
      end
      stall = stall | (id_valid & id_src_used[i] & hit_early_ld);
    end
  end

  assign bubble  = stall | flush;
  assign ex_load = id_valid & ~stall & ~flush;

  // Next-state: shift the tag pipeline and load EX from ID unless stalled or flushed.
  always_comb begin
    vld_d = {vld_q[FWD_DEPTH-1:0], ex_load};
    we_d  = {we_q[FWD_DEPTH-1:0], id_we};
    ld_d  = {ld_q[FWD_DEPTH-1:0], id_is_load};
    rd_d  = rd_q;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      rd_d[k] = rd_q[k-1];
    end
    rd_d[0]   = id_rd;
    ex_src_d  = id_src;
    ex_used_d = ex_load ? id_src_used : '0;
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      we_q      <= '0;
      ld_q      <= '0;
      rd_q      <= '0;
      ex_src_q  <= '0;
      ex_used_q <= '0;
    end else begin
      vld_q     <= vld_d;
      we_q      <= we_d;
      ld_q      <= ld_d;
      rd_q      <= rd_d;
      ex_src_q  <= ex_src_d;
      ex_used_q <= ex_used_d;
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] fwd_cnt_q, fwd_cnt_d;

  // Saturating event counters; clear takes priority over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stat_clr) begin
      stall_cnt_d = '0;
      fwd_cnt_d   = '0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
      if ((|fwd_sel) && (fwd_cnt_q != 16'hFFFF)) fwd_cnt_d = fwd_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
  assign stat_fwd_cnt   = fwd_cnt_q;
`endif

endmodule
